md_unit_p: RTL and testbench
============================

MD_UNIT_P -- requirements
Module: md_unit_p

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; legal values 8..64, even.
REQ-002 Parameter MUL_LAT, default 5, multiply-class busy cycles; legal values 1..16.
REQ-003 Parameter DIV_ITER, default WIDTH, divider iterations; fixed equal to WIDTH.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-low.
REQ-006 Port op  input  4  operation code: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11..15 treated as none.
REQ-007 Port a  input  WIDTH  operand A (dividend, multiplicand, MTHI/MTLO source).
REQ-008 Port b  input  WIDTH  operand B (divisor, multiplier).
REQ-009 Port flush  input  1  abort in-flight operation (pipeline exception/redirect).
REQ-010 Port busy  output  1  unit occupied; new ops refused.
REQ-011 Port done  output  1  one-cycle pulse: HI/LO just updated by a busy-class op.
REQ-012 Port hi  output  WIDTH  HI register.
REQ-013 Port lo  output  WIDTH  LO register.

Function
REQ-014 Acceptance: op sampled at edge k when busy=0 and flush=0; op ignored when busy=1 or flush=1.
REQ-015 States: IDLE, MUL, DIV, FIX; reset and abort go to IDLE.
REQ-016 MTHI/MTLO accepted at edge k write hi/lo at edge k; no busy, no done.
REQ-017 Busy-class op (1-4, 7-10) accepted at edge k: busy=1 from edge k through edge k+L-1; at edge k+L hi/lo written, busy<=0, done<=1 for one cycle.
REQ-018 L = MUL_LAT for ops 1,2,7-10; L = WIDTH+1 for ops 3,4 (WIDTH iterations in DIV, one sign-fix cycle in FIX).
REQ-019 hi/lo hold previous values throughout busy period; updated only at completion.
REQ-020 Operands latched at acceptance; a/b changes during busy have no effect.
REQ-021 MULT/MULTU: {hi,lo} = 2*WIDTH-bit signed/unsigned product.
REQ-022 MADD/MADDU: {hi,lo} = {hi,lo} + product; MSUB/MSUBU: {hi,lo} = {hi,lo} - product; modulo 2^(2*WIDTH); HI/LO value used is that present at completion edge.
REQ-023 DIV/DIVU: radix-2 restoring division on magnitudes; lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-024 Divide by zero (b=0): lo = all ones, hi = a; full L latency, done pulses.
REQ-025 Signed overflow (DIV, a = most negative, b = -1): lo = a, hi = 0.
REQ-026 flush=1 while busy: state to IDLE at next edge, busy<=0, no done, hi/lo unchanged; op on same cycle not accepted.
REQ-027 flush=1 on the completion edge k+L: completion suppressed, hi/lo unchanged, no done.
REQ-028 A new op may be accepted in the cycle done=1 (busy=0 then); back-to-back throughput is L+1 cycles per op.
REQ-029 done never asserted for MTHI/MTLO, ignored ops, or flushed ops.

Reset
REQ-030 rst=0 immediately (no clock) forces hi=0, lo=0, busy=0, done=0, state IDLE, iteration counter 0.
REQ-031 rst asserted mid-operation discards the operation; no done after release.
REQ-032 First op accepted on the first rising edge with rst=1.

Verification
REQ-033 WIDTH=32, MUL_LAT=5: MULT a=0xFFFFFFFE, b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done 1 cycle.
REQ-034 MTHI 0, MTLO 10, MADDU a=0xFFFFFFFF, b=2 -> hi=0x00000002, lo=0x00000008 after 5 busy cycles.
REQ-035 DIV a=-7 (0xFFFFFFF9), b=2 -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-036 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 DIVU started with hi=0x11, lo=0x22; flush at busy cycle 10 -> busy low next cycle, hi=0x11, lo=0x22, no done; MULT issued while busy is ignored.
REQ-038 rst pulsed low between edges during MULT -> hi=lo=0 and busy=0 without clock edge; no done afterwards.

Source files
------------

// File: rtl/md_unit_p.sv
// Multiply/divide unit with HI/LO registers and multi-cycle busy timing.
// Multiplies complete after MUL_LAT cycles; divides run WIDTH restoring steps plus a sign-fix cycle.
module md_unit_p #(
  parameter int WIDTH    = 32,
  parameter int MUL_LAT  = 5,
  parameter int DIV_ITER = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + MUL_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_negQ;
  logic               r_negR;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_accept;
  logic               w_isMul;
  logic               w_isDiv;
  logic               w_signedIn;
  logic               w_mulSigned;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [2*WIDTH-1:0] w_ax;
  logic [2*WIDTH-1:0] w_bx;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mulRes;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;

  assign w_accept    = (r_state == S_IDLE) && !flush;
  assign w_isMul     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                       (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  assign w_isDiv     = (op == OP_DIV) || (op == OP_DIVU);
  assign w_signedIn  = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  assign w_absA      = (w_signedIn && a[WIDTH-1]) ? -a : a;
  assign w_absB      = (w_signedIn && b[WIDTH-1]) ? -b : b;

  assign w_mulSigned = (r_op == OP_MULT) || (r_op == OP_MADD) || (r_op == OP_MSUB);
  assign w_ax        = w_mulSigned ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_bx        = w_mulSigned ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod      = w_ax * w_bx;

  // Accumulating ops read HI/LO as they stand on the completion edge.
  always_comb begin
    w_mulRes = w_prod;
    case (r_op)
      OP_MADD, OP_MADDU: w_mulRes = {r_hi, r_lo} + w_prod;
      OP_MSUB, OP_MSUBU: w_mulRes = {r_hi, r_lo} - w_prod;
      default:           w_mulRes = w_prod;
    endcase
  end

  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_trial  = w_shift - {1'b0, r_dvs};
  // Most-negative / -1 needs no special case: the magnitude quotient wraps back to a.
  assign w_quoFix = r_negQ ? -r_quo : r_quo;
  assign w_remFix = r_negR ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_isMul)      w_next = S_MUL;
        else if (w_accept && w_isDiv) w_next = S_DIV;
      end
      S_MUL:   if (r_cnt == '0) w_next = S_IDLE;
      S_DIV:   if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_negQ <= 1'b0;
      r_negR <= 1'b0;
      r_dz   <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (op == OP_MTHI) r_hi <= a;
        if (op == OP_MTLO) r_lo <= a;
        if (w_isMul || w_isDiv) begin
          r_op   <= op;
          r_a    <= a;
          r_b    <= b;
          r_cnt  <= w_isMul ? CW'(MUL_LAT - 1) : CW'(DIV_ITER - 1);
          r_rem  <= '0;
          r_quo  <= w_absA;
          r_dvs  <= w_absB;
          r_negQ <= w_signedIn && (a[WIDTH-1] ^ b[WIDTH-1]);
          r_negR <= w_signedIn && a[WIDTH-1];
          r_dz   <= (b == '0);
        end
      end else if (!flush) begin
        case (r_state)
          S_MUL: begin
            if (r_cnt == '0) begin
              {r_hi, r_lo} <= w_mulRes;
              r_done       <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_DIV: begin
            if (!w_trial[WIDTH]) begin
              r_rem <= w_trial[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
              r_rem <= w_shift[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          end
          S_FIX: begin
            r_lo   <= r_dz ? {WIDTH{1'b1}} : w_quoFix;
            r_hi   <= r_dz ? r_a : w_remFix;
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit_p.sv
// Directed bench for md_unit_p at WIDTH=32, MUL_LAT=5 with hand-computed HI/LO results.
module tb_md_unit_p;

  localparam int W    = 32;
  localparam int LMUL = 5;
  localparam int LDIV = W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] expHi = '0;
  logic [W-1:0] expLo = '0;

  md_unit_p #(.WIDTH(W), .MUL_LAT(LMUL)) dut (
    .clk(clk), .rst(rst), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o;
    a  = x;
    b  = y;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
    checkOutput({tag, ".done"}, 64'(done), 64'd0);
    checkOutput({tag, ".hi"}, 64'(hi), 64'(expHi));
    checkOutput({tag, ".lo"}, 64'(lo), 64'(expLo));
  endtask

  task automatic moveTo(input string tag, input logic [3:0] o, input logic [W-1:0] v);
    applyStimulus(o, v, 32'h0);
    tick();
    applyStimulus(4'd0, 32'h0, 32'h0);
    if (o == 4'd5) expHi = v;
    else           expLo = v;
    checkIdle(tag);
  endtask

  // Accept one busy-class op, watch HI/LO hold for the whole latency, then check the completion pulse.
  task automatic runOp(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int lat,
                       input logic [W-1:0] newHi, input logic [W-1:0] newLo);
    applyStimulus(o, x, y);
    tick();
    applyStimulus(4'd0, 32'hDEADBEEF, 32'h00000001);
    checkOutput({tag, ".busy0"}, 64'(busy), 64'd1);
    for (int i = 1; i < lat; i++) begin
      tick();
      checkOutput({tag, ".busy"}, 64'(busy), 64'd1);
      checkOutput({tag, ".hold"}, {hi, lo}, {expHi, expLo});
      checkOutput({tag, ".nodone"}, 64'(done), 64'd0);
    end
    tick();
    checkOutput({tag, ".busyEnd"}, 64'(busy), 64'd0);
    checkOutput({tag, ".done"}, 64'(done), 64'd1);
    checkOutput({tag, ".hi"}, 64'(hi), 64'(newHi));
    checkOutput({tag, ".lo"}, 64'(lo), 64'(newLo));
    expHi = newHi;
    expLo = newLo;
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    checkIdle("reset");

    @(negedge clk);
    rst = 1'b1;
    runOp("mult", 4'd1, 32'hFFFFFFFE, 32'd3, LMUL, 32'hFFFFFFFF, 32'hFFFFFFFA);
    moveTo("mthi", 4'd5, 32'h0);
    checkOutput("doneDrop", 64'(done), 64'd0);
    moveTo("mtlo", 4'd6, 32'd10);
    runOp("maddu", 4'd8, 32'hFFFFFFFF, 32'd2, LMUL, 32'h00000002, 32'h00000008);
    runOp("msub", 4'd9, 32'd3, 32'hFFFFFFFE, LMUL, 32'h00000002, 32'h0000000E);
    runOp("msubu", 4'd10, 32'd1, 32'h10, LMUL, 32'h00000001, 32'hFFFFFFFE);
    runOp("madd", 4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, LMUL, 32'h00000001, 32'hFFFFFFFF);
    runOp("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, LMUL, 32'hFFFFFFFE, 32'h00000001);

    runOp("divNeg", 4'd3, 32'hFFFFFFF9, 32'd2, LDIV, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("divuZero", 4'd4, 32'd7, 32'd0, LDIV, 32'h00000007, 32'hFFFFFFFF);
    runOp("divOvf", 4'd3, 32'h80000000, 32'hFFFFFFFF, LDIV, 32'h00000000, 32'h80000000);
    runOp("divu", 4'd4, 32'd100, 32'd7, LDIV, 32'h00000002, 32'h0000000E);
    runOp("divNegB", 4'd3, 32'd7, 32'hFFFFFFFE, LDIV, 32'h00000001, 32'hFFFFFFFD);
    runOp("divuBig", 4'd4, 32'hFFFFFFFF, 32'h10, LDIV, 32'h0000000F, 32'h0FFFFFFF);

    moveTo("mthi11", 4'd5, 32'h11);
    moveTo("mtlo22", 4'd6, 32'h22);
    applyStimulus(4'd4, 32'd50, 32'd3);
    tick();
    applyStimulus(4'd1, 32'd5, 32'd5);
    checkOutput("flushBusy0", 64'(busy), 64'd1);
    for (int i = 1; i < 10; i++) begin
      tick();
      checkOutput("flushBusy", 64'(busy), 64'd1);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(4'd0, 32'h0, 32'h0);
    checkIdle("flushMid");
    for (int i = 0; i < 3; i++) begin
      tick();
      checkIdle("flushAfter");
    end

    applyStimulus(4'd1, 32'd2, 32'd2);
    tick();
    applyStimulus(4'd0, 32'h0, 32'h0);
    for (int i = 1; i < LMUL; i++) tick();
    checkOutput("flushEndBusy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkIdle("flushEnd");
    tick();
    checkIdle("flushEndAfter");

    applyStimulus(4'd1, 32'd3, 32'd3);
    tick();
    applyStimulus(4'd0, 32'h0, 32'h0);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    expHi = '0;
    expLo = '0;
    checkIdle("asyncRst");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkIdle("postRst");
    end

    moveTo("mtloFirst", 4'd6, 32'd5);
    applyStimulus(4'd12, 32'd9, 32'd9);
    tick();
    applyStimulus(4'd0, 32'h0, 32'h0);
    checkIdle("badOp");
    tick();
    checkIdle("badOpAfter");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
